serial_alu: RTL and testbench

Parametrised multi-cycle ALU. It computes AND, OR, ADD/SUB and SLT on WIDTH-bit operands, SLICE bits per clock, LSB slice first, with a registered ripple carry between slices. Operand inversion and carry-in control follow the single-bit ALU slice convention (Ainvert/Binvert/CarryIn/operation). It sits behind the datapath controller as a low-area execution unit with a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_slice.sv | 30 +++
 rtl/serial_alu.sv | 146 ++++++++++++++
 tb/tb_serial_alu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings and state type for the slice-serial ALU.
package alu_pkg;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice: AND / OR / ripple sum with carry-in.
module alu_slice
    import alu_pkg::*;
#(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] ma_i,
    input  logic [SLICE-1:0] mb_i,
    input  logic             cin_i,
    input  logic [1:0]       op_i,
    output logic [SLICE-1:0] res_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [SLICE:0] sum_ext;

    always_comb begin
        sum_ext = {1'b0, ma_i} + {1'b0, mb_i} + (SLICE+1)'(cin_i);
        case (op_i)
            ALU_AND: res_o = ma_i & mb_i;
            ALU_OR:  res_o = ma_i | mb_i;
            default: res_o = sum_ext[SLICE-1:0];
        endcase
        cout_o = sum_ext[SLICE];
        // carry into the slice MSB, recovered from its sum bit
        cmsb_o = ma_i[SLICE-1] ^ mb_i[SLICE-1] ^ sum_ext[SLICE-1];
    end

endmodule

// File: rtl/serial_alu.sv
// Multi-cycle ALU: processes SLICE bits per clock, LSB slice first, with a
// registered carry between slices and a start/busy/done handshake.
module serial_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ainvert,
    input  logic             binvert,
    input  logic             carry_in,
    input  logic [1:0]       operation,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
    logic [1:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carryout_q, carryout_d, overflow_q, overflow_d, zero_q, zero_d;

    logic [SLICE-1:0]   sl_res;
    logic               sl_cout, sl_cmsb;
    logic [WIDTH-1:0]   acc_next, fin_res;
    logic               ovf, is_arith;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .ma_i   (ma_q[SLICE-1:0]),
        .mb_i   (mb_q[SLICE-1:0]),
        .cin_i  (carry_q),
        .op_i   (op_q),
        .res_o  (sl_res),
        .cout_o (sl_cout),
        .cmsb_o (sl_cmsb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ma_q       <= '0;
            mb_q       <= '0;
            acc_q      <= '0;
            op_q       <= ALU_AND;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        acc_d      = acc_q;
        op_d       = op_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        // new slice enters at the top; after NSLICE shifts slice 0 sits at bit 0
        acc_next = (acc_q >> SLICE) | (WIDTH'(sl_res) << (WIDTH - SLICE));
        ovf      = sl_cmsb ^ sl_cout;
        is_arith = op_q[1];
        fin_res  = (op_q == ALU_SLT) ? {{(WIDTH-1){1'b0}}, acc_next[WIDTH-1] ^ ovf} : acc_next;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ma_d    = ainvert ? ~a : a;
                    mb_d    = binvert ? ~b : b;
                    op_d    = operation;
                    carry_d = carry_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_next;
                carry_d = sl_cout;
                ma_d    = ma_q >> SLICE;
                mb_d    = mb_q >> SLICE;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NSLICE - 1)) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    result_d   = fin_res;
                    carryout_d = is_arith & sl_cout;
                    overflow_d = is_arith & ovf;
                    zero_d     = (fin_res == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu at SLICE=4, SLICE=1 and SLICE=32.
module tb_serial_alu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ainvert, binvert, carry_in;
    logic [1:0]  operation;
    logic [31:0] a, b;
    logic        start4, start1, start32;

    logic        busy4, done4, co4, ov4, z4;
    logic        busy1, done1, co1, ov1, z1;
    logic        busy32, done32, co32, ov32, z32;
    logic [31:0] res4, res1, res32;

    serial_alu #(.WIDTH(32), .SLICE(4)) u_s4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .ainvert(ainvert),
        .binvert(binvert), .carry_in(carry_in), .operation(operation),
        .busy(busy4), .done(done4), .result(res4), .carryout(co4), .overflow(ov4), .zero(z4));

    serial_alu #(.WIDTH(32), .SLICE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .ainvert(ainvert),
        .binvert(binvert), .carry_in(carry_in), .operation(operation),
        .busy(busy1), .done(done1), .result(res1), .carryout(co1), .overflow(ov1), .zero(z1));

    serial_alu #(.WIDTH(32), .SLICE(32)) u_s32 (
        .clk(clk), .rst(rst), .start(start32), .a(a), .b(b), .ainvert(ainvert),
        .binvert(binvert), .carry_in(carry_in), .operation(operation),
        .busy(busy32), .done(done32), .result(res32), .carryout(co32), .overflow(ov32), .zero(z32));

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
        int          done_cyc;
    } exp_t;

    exp_t q4[$], q1[$], q32[$];
    exp_t e4, e1, e32;
    int   checks = 0, errors = 0, cyc = 0, last_done4 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input logic [31:0] r,
                              input logic co, input logic ov, input logic z, input logic bsy);
        chk({tag, " result"},   r,           e.res);
        chk({tag, " carryout"}, 32'(co),     32'(e.co));
        chk({tag, " overflow"}, 32'(ov),     32'(e.ov));
        chk({tag, " zero"},     32'(z),      32'(e.z));
        chk({tag, " busy@done"},32'(bsy),    32'd0);
        chk({tag, " latency"},  32'(cyc),    32'(e.done_cyc));
    endtask

    // monitors: pop and compare whenever a DUT pulses done
    always @(negedge clk) if (!rst && done4) begin
        if (q4.size() == 0) chk("spurious done s4", 32'(done4), 32'd0);
        else begin
            e4 = q4.pop_front();
            check_done("s4", e4, res4, co4, ov4, z4, busy4);
            last_done4 = cyc;
        end
    end

    always @(negedge clk) if (!rst && done1) begin
        if (q1.size() == 0) chk("spurious done s1", 32'(done1), 32'd0);
        else begin
            e1 = q1.pop_front();
            check_done("s1", e1, res1, co1, ov1, z1, busy1);
        end
    end

    always @(negedge clk) if (!rst && done32) begin
        if (q32.size() == 0) chk("spurious done s32", 32'(done32), 32'd0);
        else begin
            e32 = q32.pop_front();
            check_done("s32", e32, res32, co32, ov32, z32, busy32);
        end
    end

    function automatic int qsize(input int which);
        if (which == 4) return q4.size();
        if (which == 1) return q1.size();
        return q32.size();
    endfunction

    task automatic push_exp(input int which, input logic [31:0] er, input logic eco,
                            input logic eov, input logic ez, input int lat);
        exp_t e;
        e.res = er; e.co = eco; e.ov = eov; e.z = ez; e.done_cyc = cyc + lat;
        if (which == 4) q4.push_back(e);
        else if (which == 1) q1.push_back(e);
        else q32.push_back(e);
    endtask

    task automatic drive(input logic [1:0] op, input logic ai, input logic bi, input logic ci,
                         input logic [31:0] av, input logic [31:0] bv);
        a = av; b = bv; ainvert = ai; binvert = bi; carry_in = ci; operation = op;
    endtask

    task automatic issue(input int which, input logic [1:0] op, input logic ai, input logic bi,
                         input logic ci, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] er, input logic eco, input logic eov, input logic ez);
        @(negedge clk);
        drive(op, ai, bi, ci, av, bv);
        if (which == 4) start4 = 1'b1;
        else if (which == 1) start1 = 1'b1;
        else start32 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; start1 = 1'b0; start32 = 1'b0;
        push_exp(which, er, eco, eov, ez, (which == 4) ? 8 : (which == 1) ? 32 : 1);
    endtask

    task automatic wait_idle(input int which);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (qsize(which) == 0) break;
        end
        chk("drain timeout", 32'(qsize(which)), 32'd0);
    endtask

    int d1;

    initial begin
        rst = 1'b1; start4 = 1'b0; start1 = 1'b0; start32 = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("reset busy", 32'(busy4), 32'd0);
        chk("reset done", 32'(done4), 32'd0);
        chk("reset result", res4, 32'd0);
        chk("reset carryout", 32'(co4), 32'd0);
        chk("reset overflow", 32'(ov4), 32'd0);
        chk("reset zero", 32'(z4), 32'd0);

        // op      ai bi ci  a             b             result        co ov z
        issue(4, 2'b10, 0, 0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0); wait_idle(4);
        issue(4, 2'b10, 0, 1, 1, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 1); wait_idle(4);
        issue(4, 2'b11, 0, 1, 1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, 0, 0); wait_idle(4);
        issue(4, 2'b11, 0, 1, 1, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 0, 0, 1); wait_idle(4);
        issue(4, 2'b11, 0, 1, 1, 32'h80000000, 32'h00000001, 32'h00000001, 1, 1, 0); wait_idle(4);
        issue(4, 2'b00, 1, 1, 0, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 0, 0, 0); wait_idle(4);
        issue(4, 2'b01, 0, 0, 0, 32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 0); wait_idle(4);
        issue(4, 2'b10, 0, 0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1); wait_idle(4);

        // start held through RUN with changing operands: only 3+4 executes
        @(negedge clk);
        drive(2'b10, 0, 0, 0, 32'd3, 32'd4);
        start4 = 1'b1;
        @(posedge clk); #1;
        push_exp(4, 32'd7, 0, 0, 0, 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(2'b01, 1, 0, 1, 32'd100 + 32'(i), 32'hDEAD0000);
        end
        start4 = 1'b0;
        wait_idle(4);
        repeat (4) @(negedge clk);

        // back-to-back: start presented in the done cycle
        issue(4, 2'b10, 0, 0, 0, 32'd10, 32'd20, 32'd30, 0, 0, 0);
        d1 = -100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done4) begin d1 = cyc; break; end
        end
        chk("b2b first done seen", 32'(done4), 32'd1);
        drive(2'b00, 0, 0, 0, 32'hFF00FF00, 32'h0FF00FF0);
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        push_exp(4, 32'h0F000F00, 0, 0, 0, 8);
        wait_idle(4);
        chk("b2b done spacing", 32'(last_done4 - d1), 32'd9);

        // reset three cycles into RUN aborts with no done
        @(negedge clk);
        drive(2'b10, 0, 0, 0, 32'h11111111, 32'h22222222);
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy4), 32'd0);
        chk("abort result", res4, 32'd0);
        chk("abort flags", {29'd0, co4, ov4, z4}, 32'd0);
        repeat (12) @(negedge clk);
        chk("abort result held", res4, 32'd0);
        chk("abort busy held", 32'(busy4), 32'd0);

        // latency extremes
        issue(1, 2'b10, 0, 0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0); wait_idle(1);
        issue(32, 2'b10, 0, 0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0); wait_idle(32);
        issue(32, 2'b10, 0, 1, 1, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 1); wait_idle(32);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
